// File: rtl/breakout_game_if.sv
// Breakout game-state bus: frame strobe and buttons in, renderer coordinates and flags out.
// frame_tick is a one-cycle strobe with no back-pressure; the engine drops ticks while an update is in flight.
interface breakout_game_if;
   logic        frame_tick;
   logic        btn_l;
   logic        btn_r;
   logic        btn_start;
   logic [10:0] paddle_h;
   logic [10:0] paddle_v;
   logic [10:0] ball_h;
   logic [10:0] ball_v;
   logic [23:0] barr;
   logic        gameover;
   logic        win;
   logic [1:0]  dbg_state;

   modport master (
      output frame_tick, btn_l, btn_r, btn_start,
      input  paddle_h, paddle_v, ball_h, ball_v, barr, gameover, win, dbg_state
   );

   modport slave (
      input  frame_tick, btn_l, btn_r, btn_start,
      output paddle_h, paddle_v, ball_h, ball_v, barr, gameover, win, dbg_state
   );
endinterface

// File: rtl/breakout_game_ctrl.sv
// Per-frame breakout engine: paddle motion, ball motion, wall/paddle/brick/floor collisions.
// Two-stage update: stage A latches the computed next frame, stage B commits it to the outputs.
module breakout_game_ctrl #(
   parameter int SCR_W       = 640,
   parameter int SCR_H       = 480,
   parameter int PADDLE_W    = 100,
   parameter int PADDLE_H    = 20,
   parameter int PADDLE_Y    = 20,
   parameter int PADDLE_STEP = 4,
   parameter int BALL_S      = 5,
   parameter int BALL_D      = 2
) (
   input  logic            dclk,
   input  logic            clr,
   breakout_game_if.slave  bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2, WIN = 2'd3} game_state_t;

   localparam logic signed [11:0] ZERO     = 12'sd0;
   localparam logic signed [11:0] H_MAX    = 12'(SCR_W - BALL_S);
   localparam logic signed [11:0] V_MAX    = 12'(SCR_H - BALL_S);
   localparam logic signed [11:0] P_MAX    = 12'(SCR_W - PADDLE_W);
   localparam logic signed [11:0] P_HOME   = 12'((SCR_W - PADDLE_W) / 2);
   localparam logic signed [11:0] P_STEP   = 12'(PADDLE_STEP);
   localparam logic signed [11:0] P_WID    = 12'(PADDLE_W);
   localparam logic signed [11:0] B_SIDE   = 12'(BALL_S);
   localparam logic signed [11:0] B_STEP   = 12'(BALL_D);
   localparam logic signed [11:0] B_HALF   = 12'(BALL_S / 2);
   localparam logic signed [11:0] PARK_V   = 12'(PADDLE_Y + PADDLE_H);
   localparam logic signed [11:0] PARK_OFS = 12'sd48;
   localparam logic signed [11:0] BRK_L    = 12'sd64;
   localparam logic signed [11:0] BRK_R    = 12'sd575;
   localparam logic signed [11:0] BRK_B    = 12'sd320;
   localparam logic signed [11:0] BRK_T    = 12'sd415;
   localparam logic [23:0]        ALL_BRK  = 24'hFFFFFF;

   // committed frame (dir = 1 means positive direction)
   game_state_t        state_q;
   logic signed [11:0] paddle_q, ball_h_q, ball_v_q;
   logic [23:0]        barr_q;
   logic               gameover_q, win_q, dir_x_q, dir_y_q;

   // stage A holding registers
   logic               stage_a_q;
   game_state_t        state_a;
   logic signed [11:0] paddle_a, ball_h_a, ball_v_a;
   logic [23:0]        barr_a;
   logic               gameover_a, win_a, dir_x_a, dir_y_a;

   // next-frame values
   game_state_t        n_state;
   logic signed [11:0] n_paddle, n_bh, n_bv;
   logic [23:0]        n_barr;
   logic               n_go, n_win, n_dx, n_dy;

   logic signed [11:0] step_h, step_v, cx, cy, dy_off, dx_off;
   logic [4:0]         brick_idx;
   logic [23:0]        brick_mask;
   logic               in_zone, brick_hit, paddle_hit;
   logic               unused_bits;

   always_comb begin
      n_state  = state_q;
      n_paddle = paddle_q;
      n_bh     = ball_h_q;
      n_bv     = ball_v_q;
      n_barr   = barr_q;
      n_go     = gameover_q;
      n_win    = win_q;
      n_dx     = dir_x_q;
      n_dy     = dir_y_q;

      step_h     = dir_x_q ? ball_h_q + B_STEP : ball_h_q - B_STEP;
      step_v     = dir_y_q ? ball_v_q + B_STEP : ball_v_q - B_STEP;
      cx         = step_h + B_HALF;
      cy         = step_v + B_HALF;
      dy_off     = BRK_T - cy;
      dx_off     = cx - BRK_L;
      // rows are 32 px tall and columns 64 px wide, so the index is just two bit fields
      brick_idx  = {dy_off[6:5], dx_off[8:6]};
      brick_mask = 24'd1 << brick_idx;
      in_zone    = (cx >= BRK_L) && (cx <= BRK_R) && (cy >= BRK_B) && (cy <= BRK_T);
      brick_hit  = in_zone && |(barr_q & brick_mask);
      paddle_hit = !dir_y_q && (ball_v_q > PARK_V) && (step_v <= PARK_V) &&
                   (ball_h_q + B_SIDE > paddle_q) && (ball_h_q < paddle_q + P_WID);

      if (state_q == IDLE || state_q == PLAY) begin
         if (bus.btn_l && !bus.btn_r)
            n_paddle = (paddle_q >= P_STEP) ? paddle_q - P_STEP : ZERO;
         else if (bus.btn_r && !bus.btn_l)
            n_paddle = (paddle_q <= P_MAX - P_STEP) ? paddle_q + P_STEP : P_MAX;
      end

      case (state_q)
         IDLE: begin
            n_bh = n_paddle + PARK_OFS;
            n_bv = PARK_V;
            if (bus.btn_start) begin
               n_state = PLAY;
               n_dx    = 1'b1;
               n_dy    = 1'b1;
            end
         end
         PLAY: begin
            if (step_h <= ZERO) begin
               n_bh = ZERO;
               n_dx = 1'b1;
            end else if (step_h >= H_MAX) begin
               n_bh = H_MAX;
               n_dx = 1'b0;
            end else begin
               n_bh = step_h;
            end
            // vertical outcomes are mutually exclusive, in priority order
            if (step_v >= V_MAX) begin
               n_bv = V_MAX;
               n_dy = 1'b0;
            end else if (paddle_hit) begin
               n_bv = PARK_V;
               n_dy = 1'b1;
            end else if (brick_hit) begin
               n_barr = barr_q & ~brick_mask;
               n_dy   = ~dir_y_q;
               n_bh   = ball_h_q;
               n_bv   = ball_v_q;
            end else if (step_v <= ZERO) begin
               n_bv    = ZERO;
               n_go    = 1'b1;
               n_state = OVER;
            end else begin
               n_bv = step_v;
            end
            if (n_barr == 24'd0) begin
               n_win   = 1'b1;
               n_go    = 1'b0;
               n_state = WIN;
            end
         end
         OVER, WIN: begin
            if (bus.btn_start) begin
               n_state  = IDLE;
               n_barr   = ALL_BRK;
               n_paddle = P_HOME;
               n_bh     = P_HOME + PARK_OFS;
               n_bv     = PARK_V;
               n_go     = 1'b0;
               n_win    = 1'b0;
               n_dx     = 1'b1;
               n_dy     = 1'b1;
            end
         end
         default: n_state = IDLE;
      endcase
   end

   always_ff @(posedge dclk) begin
      if (!clr) begin
         stage_a_q  <= 1'b0;
         state_q    <= IDLE;
         paddle_q   <= P_HOME;
         ball_h_q   <= P_HOME + PARK_OFS;
         ball_v_q   <= PARK_V;
         barr_q     <= ALL_BRK;
         gameover_q <= 1'b0;
         win_q      <= 1'b0;
         dir_x_q    <= 1'b1;
         dir_y_q    <= 1'b1;
         state_a    <= IDLE;
         paddle_a   <= P_HOME;
         ball_h_a   <= P_HOME + PARK_OFS;
         ball_v_a   <= PARK_V;
         barr_a     <= ALL_BRK;
         gameover_a <= 1'b0;
         win_a      <= 1'b0;
         dir_x_a    <= 1'b1;
         dir_y_a    <= 1'b1;
      end else begin
         stage_a_q <= 1'b0;
         if (bus.frame_tick && !stage_a_q) begin
            stage_a_q  <= 1'b1;
            state_a    <= n_state;
            paddle_a   <= n_paddle;
            ball_h_a   <= n_bh;
            ball_v_a   <= n_bv;
            barr_a     <= n_barr;
            gameover_a <= n_go;
            win_a      <= n_win;
            dir_x_a    <= n_dx;
            dir_y_a    <= n_dy;
         end
         if (stage_a_q) begin
            state_q    <= state_a;
            paddle_q   <= paddle_a;
            ball_h_q   <= ball_h_a;
            ball_v_q   <= ball_v_a;
            barr_q     <= barr_a;
            gameover_q <= gameover_a;
            win_q      <= win_a;
            dir_x_q    <= dir_x_a;
            dir_y_q    <= dir_y_a;
         end
      end
   end

   assign bus.paddle_h  = paddle_q[10:0];
   assign bus.paddle_v  = 11'(PADDLE_Y);
   assign bus.ball_h    = ball_h_q[10:0];
   assign bus.ball_v    = ball_v_q[10:0];
   assign bus.barr      = barr_q;
   assign bus.gameover  = gameover_q;
   assign bus.win       = win_q;
   assign bus.dbg_state = state_q;

   // sign bits never leave 0 because every coordinate is clamped into the screen
   assign unused_bits = ^{paddle_q[11], ball_h_q[11], ball_v_q[11],
                          dy_off[11:7], dy_off[4:0], dx_off[11:9], dx_off[5:0]};
endmodule
